// File: rtl/priority_extractor.sv
// Purpose: streams each set bit of an accepted request word as one beat (one-hot, index, last).
// Latency: first beat 1 clock after accept; 1 beat/cycle while ready_i is high.
// Backpressure: val_o && !ready_i holds every output and the buffer; input closes until the last beat goes.
module priority_extractor #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  input  logic             mode_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] index_o,
  output logic             last_o,
  output logic             zero_o,
  output logic             val_o,
  input  logic             ready_i
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] req_q;    // bits still to be emitted for the current word
  logic             mode_q;   // scan order latched with the word
  logic             zero_q;   // current word was all-zero

  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [WIDTH-1:0] sel_onehot;
  logic             single_bit;
  logic             beat_last;
  logic             busy;
  logic             beat_xfer;
  logic             accept;

  // Pick the lowest (mode 0) or highest (mode 1) pending bit of the buffer.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    if (!mode_q) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!sel_found && req_q[i]) begin
          sel_idx   = IDX_W'(i);
          sel_found = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (!sel_found && req_q[i]) begin
          sel_idx   = IDX_W'(i);
          sel_found = 1'b1;
        end
      end
    end
  end

  assign sel_onehot = sel_found ? (WIDTH'(1) << sel_idx) : '0;
  // Exactly one pending bit: clearing the lowest set bit leaves nothing.
  assign single_bit = (req_q != '0) && ((req_q & (req_q - WIDTH'(1))) == '0);
  assign beat_last  = zero_q || single_bit;

  assign busy         = (state_q == BUSY);
  assign beat_xfer    = busy && ready_i;
  // A new word may enter on the cycle the final beat leaves, so words run back to back.
  assign data_ready_o = !srst_i && (!busy || (beat_xfer && beat_last));
  assign accept       = data_val_i && data_ready_o;

  // Beat fields are forced to zero whenever no beat is being presented.
  assign val_o    = busy;
  assign onehot_o = busy ? sel_onehot : '0;
  assign index_o  = busy ? sel_idx : '0;
  assign last_o   = busy && beat_last;
  assign zero_o   = busy && zero_q;

  // Word load, per-beat bit clearing and IDLE/BUSY sequencing.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      mode_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      state_q <= BUSY;
      req_q   <= data_i;
      mode_q  <= mode_i;
      zero_q  <= (data_i == '0);
    end else if (beat_xfer) begin
      req_q <= req_q & ~sel_onehot;
      if (beat_last) begin
        state_q <= IDLE;
        zero_q  <= 1'b0;
      end
    end
  end

endmodule
